// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Optional feature macro: ICACHE_STATS_EN (hit/miss counters on icache_direct).
package icache_pkg;

  typedef enum logic {
    ICACHE_IDLE,
    ICACHE_FILL
  } icache_state_e;

  localparam logic [31:0] ICACHE_NOP = 32'h0000_0013;

  // Word-offset bits within a line.
  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Line-index bits.
  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag bits: whatever remains of a 32-bit byte address above offset and index.
  function automatic int tag_w(input int line_words, input int num_lines);
    return 32 - 2 - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays of the cache: one write port driven by the
// refill engine and one combinational read/compare port driven by the PC.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16,
  localparam int OW = offset_w(LINE_WORDS),
  localparam int IW = index_w(NUM_LINES),
  localparam int TW = tag_w(LINE_WORDS, NUM_LINES)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [OW-1:0] wr_offset,
  input  logic [31:0]   wr_data,
  input  logic          tag_wr,
  input  logic          tag_valid,
  input  logic [TW-1:0] wr_tag,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_offset,
  input  logic [TW-1:0] rd_tag,
  output logic          hit,
  output logic [31:0]   rd_data
);

  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];

  // Valid bits: cleared by reset or flush, rewritten when a refill completes.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (tag_wr) begin
      valid[wr_index] <= tag_valid;
    end
  end

  // Tag and data arrays: written by refill beats only.
  // NOTE: storage arrays carry no reset; the valid bits alone decide whether contents are used.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      data_mem[wr_index][wr_offset] <= wr_data;
    end
    if (tag_wr) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign rd_data = data_mem[rd_index][rd_offset];
  assign hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with in-order line refill over a
// req/ack handshake. Optional macro ICACHE_STATS_EN adds saturating hit/miss
// counters (hit_cnt_o, miss_cnt_o).
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] pc_addr_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        hit_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int OW = offset_w(LINE_WORDS);
  localparam int IW = index_w(NUM_LINES);
  localparam int TW = tag_w(LINE_WORDS, NUM_LINES);

  icache_state_e state_q, state_d;
  logic [OW-1:0] beat_q;
  logic          fill_killed_q;
  logic [TW-1:0] cap_tag_q;
  logic [IW-1:0] cap_index_q;
  logic          start_fill;
  logic          lookup_hit;
  logic [31:0]   rd_data;
  logic          fill_ack;
  logic          last_beat;

  wire [OW-1:0] pc_offset = pc_addr_i[OW+1:2];
  wire [IW-1:0] pc_index  = pc_addr_i[OW+IW+1:OW+2];
  wire [TW-1:0] pc_tag    = pc_addr_i[31:OW+IW+2];

  assign fill_ack  = (state_q == ICACHE_FILL) && mem_ack_i;
  assign last_beat = &beat_q;

  icache_line_store #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) u_store (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .flush    (flush_i),
    .wr_en    (fill_ack),
    .wr_index (cap_index_q),
    .wr_offset(beat_q),
    .wr_data  (mem_data_i),
    .tag_wr   (fill_ack && last_beat),
    .tag_valid(!fill_killed_q && !flush_i),
    .wr_tag   (cap_tag_q),
    .rd_index (pc_index),
    .rd_offset(pc_offset),
    .rd_tag   (pc_tag),
    .hit      (lookup_hit),
    .rd_data  (rd_data)
  );

  // Next-state and handshake outputs.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    hit_o      = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    start_fill = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        hit_o = lookup_hit && !flush_i;
        if (!lookup_hit && !flush_i) begin
          state_d    = ICACHE_FILL;
          start_fill = 1'b1;
        end
      end
      ICACHE_FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {cap_tag_q, cap_index_q, beat_q, 2'b00};
        if (mem_ack_i && last_beat) begin
          state_d = ICACHE_IDLE;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  assign instr_o = hit_o ? rd_data : ICACHE_NOP;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= ICACHE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat counter and kill flag for the refill in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      beat_q        <= '0;
      fill_killed_q <= 1'b0;
    end else if (start_fill) begin
      beat_q        <= '0;
      fill_killed_q <= 1'b0;
    end else if (state_q == ICACHE_FILL) begin
      if (mem_ack_i) begin
        beat_q <= beat_q + OW'(1);
      end
      if (flush_i) begin
        fill_killed_q <= 1'b1;
      end
    end
  end

  // Captured miss address; only observed while filling.
  always_ff @(posedge clk_i) begin
    if (start_fill) begin
      cap_tag_q   <= pc_tag;
      cap_index_q <= pc_index;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating hit and miss counters; flush does not touch them.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_o && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_fill && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct. Backing memory returns data equal to
// the word address, so any hitting fetch must return its own aligned PC.
// Define ICACHE_STATS_EN to also check the hit/miss counters.
module tb_icache_direct;

  localparam int LW = 4;
  localparam int NL = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        flush;
  logic [31:0] instr;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  assign mem_data = mem_addr;

  always #5 clk = ~clk;

  icache_direct #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .pc_addr_i (pc_addr),
    .flush_i   (flush),
    .instr_o   (instr),
    .hit_o     (hit),
    .mem_req_o (mem_req),
    .mem_addr_o(mem_addr),
    .mem_ack_i (mem_ack),
    .mem_data_i(mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Resident lines as (valid, tag) per index; a refill in flight as
  // (line base address, words received, killed).
  bit          model_ok = 0;
  bit          m_valid[NL];
  int unsigned m_tag[NL];
  bit          busy;
  logic [31:0] fill_base;
  int          beats;
  bit          killed;
  logic [31:0] m_hits, m_misses;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / (LW * 4)) % NL;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LW * 4 * NL);
  endfunction

  function automatic bit resident(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      model_ok = 1;
      busy     = 0;
      m_hits   = 0;
      m_misses = 0;
      for (int i = 0; i < NL; i++) m_valid[i] = 0;
    end else if (model_ok) begin
      if (busy) begin
        if (mem_ack) beats++;
        if (flush) begin
          killed = 1;
          for (int i = 0; i < NL; i++) m_valid[i] = 0;
        end
        if (beats == LW) begin
          busy = 0;
          m_tag[idx_of(fill_base)]   = tag_of(fill_base);
          m_valid[idx_of(fill_base)] = !killed;
        end
      end else if (flush) begin
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
      end else if (resident(pc_addr)) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits++;
      end else begin
        busy      = 1;
        fill_base = pc_addr & ~32'(LW * 4 - 1);
        beats     = 0;
        killed    = 0;
        if (m_misses != 32'hFFFF_FFFF) m_misses++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (model_ok) begin
        logic        e_hit;
        logic [31:0] e_addr;
        e_hit  = !busy && !flush && resident(pc_addr);
        e_addr = busy ? fill_base + 32'(beats * 4) : 32'h0;
        check("m_hit", {31'b0, hit}, {31'b0, e_hit});
        check("m_instr", instr, e_hit ? {pc_addr[31:2], 2'b00} : NOP);
        check("m_req", {31'b0, mem_req}, {31'b0, busy});
        check("m_addr", mem_addr, e_addr);
`ifdef ICACHE_STATS_EN
        check("m_hit_cnt", hit_cnt, m_hits);
        check("m_miss_cnt", miss_cnt, m_misses);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] pc, input logic fl, input logic ack, input logic rst);
    @(negedge clk);
    pc_addr = pc;
    flush   = fl;
    mem_ack = ack;
    rst_n   = rst;
  endtask

  task automatic fill_to_hit(input logic [31:0] pc);
    int n = 0;
    do begin
      step(pc, 1'b0, 1'b1, 1'b1);
      #3;
      n++;
    end while (!hit && n < 20);
    check("fill_to_hit", {31'b0, hit}, 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    pc_addr = '0;
    flush   = 1'b0;
    mem_ack = 1'b0;

    // Reset state.
    step(32'h0, 1'b0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    check("rst_hit", {31'b0, hit}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);

    // Cold miss at 0x100 with zero-wait memory, then a hit in cycle 5.
    step(32'h100, 1'b0, 1'b1, 1'b1);
    #3;
    check("cold_c0_hit", {31'b0, hit}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(32'h100, 1'b0, 1'b1, 1'b1);
      #3;
      check("cold_req", {31'b0, mem_req}, 32'd1);
      check("cold_addr", mem_addr, 32'h100 + 32'(4 * (k - 1)));
      check("cold_nohit", {31'b0, hit}, 32'd0);
    end
    step(32'h100, 1'b0, 1'b1, 1'b1);
    #3;
    check("cold_c5_hit", {31'b0, hit}, 32'd1);
    check("cold_c5_instr", instr, 32'h100);
    step(32'h108, 1'b0, 1'b0, 1'b1);
    #3;
    check("hit_108", {31'b0, hit}, 32'd1);
    check("instr_108", instr, 32'h108);

    // Flush in IDLE forces a miss-free cycle, then wait-state refill.
    step(32'h100, 1'b1, 1'b0, 1'b1);
    #3;
    check("flush_idle_hit", {31'b0, hit}, 32'd0);
    step(32'h100, 1'b0, 1'b0, 1'b1);
    #3;
    check("ws_c0_hit", {31'b0, hit}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step(32'h100, 1'b0, (k % 2) == 0, 1'b1);
      #3;
      check("ws_addr", mem_addr, 32'h100 + 32'(4 * ((k - 1) / 2)));
    end
    step(32'h100, 1'b0, 1'b0, 1'b1);
    #3;
    check("ws_c9_hit", {31'b0, hit}, 32'd1);

    // Conflict eviction: 0x000 and 0x100 share index 0.
    fill_to_hit(32'h000);
    check("conf_instr_0", instr, 32'h0);
    step(32'h100, 1'b0, 1'b1, 1'b1);
    #3;
    check("conf_100_miss", {31'b0, hit}, 32'd0);
    fill_to_hit(32'h100);
    step(32'h000, 1'b0, 1'b1, 1'b1);
    #3;
    check("conf_000_miss", {31'b0, hit}, 32'd0);
    fill_to_hit(32'h000);

    // Flush during beat 2: all beats complete, line stays invalid.
    begin
      logic [31:0] miss_before;
`ifdef ICACHE_STATS_EN
      miss_before = miss_cnt;
`else
      miss_before = 32'h0;
`endif
      step(32'h200, 1'b0, 1'b1, 1'b1);
      #3;
      check("fk_c0_hit", {31'b0, hit}, 32'd0);
      for (int k = 1; k <= 4; k++) begin
        step(32'h200, k == 3, 1'b1, 1'b1);
        #3;
        check("fk_req", {31'b0, mem_req}, 32'd1);
        check("fk_addr", mem_addr, 32'h200 + 32'(4 * (k - 1)));
      end
      step(32'h200, 1'b0, 1'b1, 1'b1);
      #3;
      check("fk_c5_hit", {31'b0, hit}, 32'd0);
      check("fk_c5_req", {31'b0, mem_req}, 32'd0);
      step(32'h200, 1'b0, 1'b1, 1'b1);
      #3;
      check("fk_c6_req", {31'b0, mem_req}, 32'd1);
`ifdef ICACHE_STATS_EN
      check("fk_miss_cnt", miss_cnt, miss_before + 32'd2);
`else
      miss_before = miss_before + 32'd0;
`endif
      fill_to_hit(32'h200);
    end

    // Reset during beat 1 of a refill.
    fill_to_hit(32'h040);
    step(32'h300, 1'b0, 1'b1, 1'b1);
    step(32'h300, 1'b0, 1'b1, 1'b1);
    #3;
    check("rmf_beat0", mem_addr, 32'h300);
    step(32'h300, 1'b0, 1'b0, 1'b0);
    #3;
    check("rmf_beat1", mem_addr, 32'h304);
    step(32'h040, 1'b0, 1'b0, 1'b1);
    #3;
    check("rmf_req_drop", {31'b0, mem_req}, 32'd0);
    check("rmf_post_miss", {31'b0, hit}, 32'd0);
    step(32'h040, 1'b0, 1'b0, 1'b1);
    #3;
    check("rmf_refill_addr", mem_addr, 32'h040);
    fill_to_hit(32'h040);

`ifdef ICACHE_STATS_EN
    // Hit counter saturation.
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    m_hits = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    for (int k = 0; k < 3; k++) begin
      step(32'h044, 1'b0, 1'b0, 1'b1);
    end
    #3;
    check("sat_hit_cnt", hit_cnt, 32'hFFFF_FFFF);
`endif

    // Randomized traffic over a small address window to mix hits and misses.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      step(pc, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
           $urandom_range(0, 199) != 0);
    end

    step(32'h0, 1'b0, 1'b0, 1'b1);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
